// File: rtl/pingpong_sched_pkg.sv
// Shared state encoding and default sizing for the ping-pong read scheduler.
package pingpong_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_BURST    = 3'd3,
    S_GAP      = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  localparam int unsigned DEF_BLOCK_WORDS  = 4096;
  localparam int unsigned DEF_TOTAL_BLOCKS = 118;
  localparam int unsigned DEF_GAP_CYCLES   = 4;

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchronizer for a level from another clock domain, plus a one-cycle rise pulse.
module sync_rise_det (
  input  logic clk,
  input  logic rst_bar,
  input  logic din,
  output logic level,
  output logic rise
);

  // [0],[1] form the synchronizer; [2] remembers the previous synced level
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], din};
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pingpong_read_scheduler.sv
// Read-side sequencer: drains one block per filled bank, throttled by the host pipe,
// and stops after a programmed number of blocks.
module pingpong_read_scheduler
  import pingpong_sched_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS  = DEF_BLOCK_WORDS,
  parameter int unsigned TOTAL_BLOCKS = DEF_TOTAL_BLOCKS,
  parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int unsigned WCNT_W       = 13,
  parameter int unsigned BCNT_W       = 10
) (
  input  logic              clk,
  input  logic              rst_bar,
  input  logic              start,
  input  logic              abort,
  input  logic              ep_ready,
  input  logic              host_rd_en,
  output logic              ep_read,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [BCNT_W-1:0] block_count,
  output logic [WCNT_W-1:0] word_count,
  output logic [2:0]        state
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(BLOCK_WORDS - 1);
  localparam logic [BCNT_W-1:0] BLK_TOTAL = BCNT_W'(TOTAL_BLOCKS);
  localparam logic [BCNT_W-1:0] BLK_LAST  = BCNT_W'(TOTAL_BLOCKS - 1);
  localparam logic [GW-1:0]     GAP_LAST  = GW'(GAP_CYCLES - 1);

  state_e            state_q;
  logic              pending_q;
  logic              overrun_q;
  logic [WCNT_W-1:0] word_q;
  logic [BCNT_W-1:0] block_q;
  logic [GW-1:0]     gap_q;
  logic              rdy_level;
  logic              rdy_edge;

  sync_rise_det u_rdy_sync (
    .clk     (clk),
    .rst_bar (rst_bar),
    .din     (ep_ready),
    .level   (rdy_level),
    .rise    (rdy_edge)
  );

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      word_q    <= '0;
      block_q   <= '0;
      gap_q     <= '0;
    end else if (abort) begin
      // counters and overrun stay visible for host readout
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
    end else begin
      // a bank filling while a block is in flight queues once, then overruns
      if (rdy_edge && (state_q == S_BURST || state_q == S_GAP)) begin
        if (pending_q) overrun_q <= 1'b1;
        else           pending_q <= 1'b1;
      end
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_ARM;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            word_q    <= '0;
            block_q   <= '0;
            gap_q     <= '0;
          end
        end
        S_ARM: begin
          pending_q <= rdy_level;
          state_q   <= S_WAIT_RDY;
        end
        S_WAIT_RDY: begin
          if (pending_q || rdy_edge) begin
            state_q   <= S_BURST;
            // the pending bank is consumed; a simultaneous edge becomes the next one
            pending_q <= pending_q & rdy_edge;
          end
        end
        S_BURST: begin
          if (ep_read) begin
            if (word_q == WORD_LAST) begin
              word_q <= '0;
              gap_q  <= '0;
              if (block_q < BLK_TOTAL) block_q <= block_q + 1'b1;
              if (block_q >= BLK_LAST)  state_q <= S_DONE;
              else if (GAP_CYCLES == 0) state_q <= S_WAIT_RDY;
              else                      state_q <= S_GAP;
            end else begin
              word_q <= word_q + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_q   <= '0;
            state_q <= S_WAIT_RDY;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ep_read     = (state_q == S_BURST) & host_rd_en & ~abort;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign overrun     = overrun_q;
  assign block_count = block_q;
  assign word_count  = word_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pingpong_read_scheduler.sv
// Directed scenarios with random host throttling for the ping-pong read scheduler.
module tb_pingpong_read_scheduler;

  localparam int unsigned BW = 8;
  localparam int unsigned TB = 3;
  localparam int unsigned GC = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_BURST = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic       clk = 1'b0;
  logic       rst_bar, start, abort, ep_ready, host_rd_en;
  logic       ep_read, busy, done, overrun;
  logic [3:0] block_count, word_count;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;
  int reads;      // EP_READ highs seen in the current scenario
  int bad;        // cycles violating a per-cycle rule
  int guard;

  always #5 clk = ~clk;

  pingpong_read_scheduler #(
    .BLOCK_WORDS  (BW),
    .TOTAL_BLOCKS (TB),
    .GAP_CYCLES   (GC),
    .WCNT_W       (4),
    .BCNT_W       (4)
  ) dut (
    .clk         (clk),
    .rst_bar     (rst_bar),
    .start       (start),
    .abort       (abort),
    .ep_ready    (ep_ready),
    .host_rd_en  (host_rd_en),
    .ep_read     (ep_read),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .block_count (block_count),
    .word_count  (word_count),
    .state       (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample mid-cycle, then step to just after the next rising edge.
  task automatic tick(input bit rnd_host);
    if (rnd_host) host_rd_en = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (ep_read) begin
      reads++;
      if (!host_rd_en) bad++;
    end
    if (word_count > 4'(BW - 1)) bad++;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  initial begin
    rst_bar = 1'b0; start = 1'b0; abort = 1'b0; ep_ready = 1'b1; host_rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ep_read", ep_read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_block_count", block_count, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_state", state, ST_IDLE);
    rst_bar = 1'b1;

    // Bank already full at start: ARM picks it up, one block drains under random throttling
    ticks(4);
    start = 1'b1; tick(1'b0); start = 1'b0;
    chk("arm_state", state, ST_ARM);
    chk("arm_busy", busy, 1);
    reads = 0; bad = 0; guard = 0;
    while (reads < int'(BW) && guard < 200) begin tick(1'b1); guard++; end
    chk("a_reads", reads, BW);
    chk("a_block_count", block_count, 1);
    chk("a_state_gap", state, ST_GAP);
    chk("a_word_count", word_count, 0);
    host_rd_en = 1'b1;
    ticks(10);
    chk("a_no_extra_reads", reads, BW);
    chk("a_wait_state", state, ST_WAIT);
    chk("a_rules", bad, 0);

    // Abort from WAIT_RDY keeps counters
    abort = 1'b1; tick(1'b0); abort = 1'b0;
    chk("abort_idle", state, ST_IDLE);
    chk("abort_held_blocks", block_count, 1);

    // Full acquisition: EP_READY toggles every 40 clocks, host throttled at random
    ep_ready = 1'b0; ticks(5);
    start = 1'b1; tick(1'b0); start = 1'b0;
    chk("b_start_clears", block_count, 0);
    reads = 0; bad = 0; guard = 0;
    while (!done && guard < 800) begin
      if (guard % 40 == 39) ep_ready = ~ep_ready;
      tick(1'b1);
      guard++;
    end
    chk("b_done", done, 1);
    chk("b_state", state, ST_DONE);
    chk("b_busy", busy, 0);
    chk("b_block_count", block_count, TB);
    chk("b_reads", reads, TB * BW);
    chk("b_overrun", overrun, 0);
    chk("b_rules", bad, 0);

    // Two bank edges inside one stalled burst: first queues, second overruns
    host_rd_en = 1'b0; ep_ready = 1'b0; ticks(5);
    start = 1'b1; tick(1'b0); start = 1'b0;
    ticks(3);
    ep_ready = 1'b1; ticks(5);
    chk("c_burst", state, ST_BURST);
    ep_ready = 1'b0; ticks(4);
    ep_ready = 1'b1; ticks(5);
    chk("c_first_edge_no_ovr", overrun, 0);
    ep_ready = 1'b0; ticks(4);
    ep_ready = 1'b1; ticks(5);
    chk("c_second_edge_ovr", overrun, 1);
    chk("c_stalled_words", word_count, 0);
    host_rd_en = 1'b1; reads = 0; bad = 0; guard = 0;
    while (reads < int'(2 * BW) && guard < 100) begin tick(1'b0); guard++; end
    chk("c_reads", reads, 2 * BW);
    chk("c_block_count", block_count, 2);
    chk("c_state_gap", state, ST_GAP);
    chk("c_ovr_sticky", overrun, 1);
    chk("c_rules", bad, 0);

    // Abort at word 3: strobe gated the same cycle, word count held, START clears it
    abort = 1'b1; tick(1'b0); abort = 1'b0;
    host_rd_en = 1'b0;
    start = 1'b1; tick(1'b0); start = 1'b0;
    chk("d_ovr_cleared", overrun, 0);
    host_rd_en = 1'b1; guard = 0;
    while (!(state == ST_BURST && word_count == 4'd3) && guard < 30) begin
      tick(1'b0); guard++;
    end
    chk("d_at_word3", word_count, 3);
    abort = 1'b1;
    #1;
    chk("d_abort_gates_read", ep_read, 0);
    tick(1'b0); abort = 1'b0;
    chk("d_abort_idle", state, ST_IDLE);
    chk("d_word_held", word_count, 3);
    start = 1'b1; tick(1'b0); start = 1'b0;
    chk("d_start_clears_word", word_count, 0);
    chk("d_arm", state, ST_ARM);

    // START+ABORT together in IDLE; START ignored mid-burst
    abort = 1'b1; tick(1'b0);
    start = 1'b1; tick(1'b0); start = 1'b0; abort = 1'b0;
    chk("e_start_abort_idle", state, ST_IDLE);
    host_rd_en = 1'b0;
    start = 1'b1; tick(1'b0); start = 1'b0;
    ticks(3);
    chk("e_burst", state, ST_BURST);
    host_rd_en = 1'b1; ticks(2); host_rd_en = 1'b0;
    start = 1'b1; tick(1'b0); start = 1'b0;
    chk("e_start_ignored_state", state, ST_BURST);
    chk("e_start_ignored_words", word_count, 2);

    // Reset mid-burst drops the strobe without waiting for a clock
    host_rd_en = 1'b1;
    #1;
    chk("f_read_before_reset", ep_read, 1);
    rst_bar = 1'b0;
    #1;
    chk("f_async_read_drop", ep_read, 0);
    chk("f_async_state", state, ST_IDLE);
    chk("f_async_words", word_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
